pc_sequencer: RTL and testbench

- Fetch-side controller that owns the program counter and sequences instruction fetch for the single-issue CPU.
- Issues word requests to instruction memory over a req/ack handshake and presents fetched instructions to decode over a valid/ready handshake.
- Applies branch/jump redirects from execute and exception vectoring, and supports halt.
- Sits between the instruction memory port and the decode stage.

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 23 ++
 rtl/pc_next_reg.sv | 24 ++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK  = ~32'h3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/ack channel plus the decode valid/ready channel.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            dec_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, dec_ready
    );
endinterface

// File: rtl/pc_next_reg.sv
// Program counter register: loads either the sequential successor or a target.
module pc_next_reg
    import pc_seq_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            sel_target,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    // Sequential successor wraps naturally at 2^XLEN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_ADDR;
        else if (load)
            pc <= sel_target ? target : pc + XLEN'(INSTR_BYTES);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake and hands
// captured instructions to decode, honouring redirect, exception and halt.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(32'h80)
) (
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.master  bus,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            exc,
    input  logic            halt,
    output logic            halted,
    output logic [XLEN-1:0] pc
);

    state_t          state, state_nx;
    logic            kill, kill_nx;
    logic [XLEN-1:0] pend, pend_nx;
    logic [XLEN-1:0] instr_q, instr_pc_q;
    logic            capture;
    logic            pc_load, pc_sel_tgt;
    logic [XLEN-1:0] pc_tgt;
    logic            flush;
    logic [XLEN-1:0] flush_tgt;

    assign flush     = exc | redirect;
    assign flush_tgt = exc ? EXC_VECTOR : (redirect_target & XLEN'(ALIGN_MASK));

    pc_next_reg #(
        .XLEN       (XLEN),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .sel_target (pc_sel_tgt),
        .target     (pc_tgt),
        .pc         (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            kill       <= 1'b0;
            pend       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state <= state_nx;
            kill  <= kill_nx;
            pend  <= pend_nx;
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        kill_nx    = kill;
        pend_nx    = pend;
        capture    = 1'b0;
        pc_load    = 1'b0;
        pc_sel_tgt = 1'b0;
        pc_tgt     = flush_tgt;
        case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    if (kill || flush) begin
                        // Outstanding word belongs to the squashed path; a
                        // same-cycle flush is newer than any pending target.
                        pc_load    = 1'b1;
                        pc_sel_tgt = 1'b1;
                        pc_tgt     = flush ? flush_tgt : pend;
                        kill_nx    = 1'b0;
                    end else begin
                        capture  = 1'b1;
                        pc_load  = 1'b1;
                        state_nx = ISSUE;
                    end
                end else if (flush) begin
                    // Keep the request alive to the old address until acked.
                    pend_nx = flush_tgt;
                    kill_nx = 1'b1;
                end
            end
            ISSUE: begin
                if (flush) begin
                    pc_load    = 1'b1;
                    pc_sel_tgt = 1'b1;
                    state_nx   = FETCH;
                end else if (bus.dec_ready) begin
                    state_nx = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (exc) begin
                    pc_load    = 1'b1;
                    pc_sel_tgt = 1'b1;
                    state_nx   = FETCH;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state == ISSUE);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign halted          = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven fetches, scoreboarded
// decode handshakes and hand-written redirect/exception/halt/wrap/reset cases.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        exc;
    logic        halt;
    logic        halted;
    logic [31:0] pc;

    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN       (32),
        .RESET_ADDR (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus.master),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .exc             (exc),
        .halt            (halt),
        .halted          (halted),
        .pc              (pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          delay;
        int          stall;
        logic [31:0] addr;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[4];
    int   checks   = 0;
    int   failures = 0;
    int   mem_delay = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: acks after mem_delay waiting cycles of a held request.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset !== 1'b1 || !bus.imem_req) begin
                bus.imem_ack = 1'b0;
                wait_cnt     = 0;
            end else if (wait_cnt >= mem_delay) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = word_of(bus.imem_addr);
                wait_cnt       = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Decode side: every accepted instruction must match the next expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.instr_valid && bus.dec_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got instr_pc %h, expected no instruction", bus.instr_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_instr_pc", bus.instr_pc, mon_e.pc);
                chk("sb_instr", bus.instr, mon_e.data);
            end
        end
    end

    task automatic push_exp(input logic [31:0] a);
        sb.push_back('{pc: a, data: word_of(a)});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        bus.dec_ready   = 1'b1;
        redirect        = 1'b0;
        redirect_target = '0;
        exc             = 1'b0;
        halt            = 1'b0;
        mem_delay       = 0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", pc, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("boot_noreq", 32'(bus.imem_req), 0);
    endtask

    task automatic wait_fetch(input string name, input logic [31:0] a);
        int n;
        n = 0;
        while (!(bus.imem_req && bus.imem_ack && bus.imem_addr == a) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 60), 1);
    endtask

    task automatic drain_and_park(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(sb.size()), 0);
        @(posedge clk); #1;
        bus.dec_ready = 1'b0;
    endtask

    initial begin
        int w;
        vt[0] = '{delay: 0, stall: 0, addr: 32'h0};
        vt[1] = '{delay: 0, stall: 0, addr: 32'h4};
        vt[2] = '{delay: 3, stall: 0, addr: 32'h8};
        vt[3] = '{delay: 1, stall: 2, addr: 32'hC};

        do_reset();

        // Straight-line fetch; each entry starts one cycle before FETCH.
        for (int i = 0; i < 4; i++) begin
            mem_delay = vt[i].delay;
            push_exp(vt[i].addr);
            @(posedge clk); #1;
            bus.dec_ready = (vt[i].stall == 0);
            @(negedge clk);
            w = 0;
            while (!bus.imem_ack && w < 40) begin
                chk("wait_req", 32'(bus.imem_req), 1);
                chk("wait_addr", bus.imem_addr, vt[i].addr);
                chk("wait_novalid", 32'(bus.instr_valid), 0);
                @(negedge clk);
                w++;
            end
            chk("ack_wait_cycles", 32'(w), 32'(vt[i].delay));
            chk("ack_addr", bus.imem_addr, vt[i].addr);
            @(negedge clk);
            chk("issue_valid", 32'(bus.instr_valid), 1);
            chk("issue_pc", bus.instr_pc, vt[i].addr);
            for (int s = 0; s < vt[i].stall; s++) begin
                @(posedge clk); #1;
                if (s == vt[i].stall - 1) bus.dec_ready = 1'b1;
                @(negedge clk);
                chk("stall_valid", 32'(bus.instr_valid), 1);
                chk("stall_pc", bus.instr_pc, vt[i].addr);
            end
        end

        // Redirect while waiting on 0x10: the acked word is dropped.
        mem_delay = 2;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_req", 32'(bus.imem_req), 1);
        chk("rd_addr0", bus.imem_addr, 32'h10);
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_target = 32'h103;
        push_exp(32'h100);
        @(negedge clk);
        chk("rd_addr_held", bus.imem_addr, 32'h10);
        @(posedge clk); #1;
        redirect = 1'b0;
        mem_delay = 0;
        @(negedge clk);
        chk("rd_old_ack", 32'(bus.imem_ack), 1);
        chk("rd_old_addr", bus.imem_addr, 32'h10);
        @(negedge clk);
        chk("rd_drop_novalid", 32'(bus.instr_valid), 0);
        chk("rd_new_req", 32'(bus.imem_req), 1);
        chk("rd_new_addr", bus.imem_addr, 32'h100);

        // exc and redirect together in ISSUE: exception wins.
        @(posedge clk); #1;
        exc = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h200;
        @(negedge clk);
        chk("er_valid", 32'(bus.instr_valid), 1);
        push_exp(32'h80);
        @(posedge clk); #1;
        exc = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        chk("er_valid_drop", 32'(bus.instr_valid), 0);
        chk("er_req", 32'(bus.imem_req), 1);
        chk("er_addr", bus.imem_addr, 32'h80);
        drain_and_park("drain_redirect");

        // Halt at the handshake of 0xC, then wake with exc.
        do_reset();
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        push_exp(32'hC);
        wait_fetch("halt_reach_c", 32'hC);
        @(posedge clk); #1;
        halt = 1'b1;
        @(negedge clk);
        chk("halt_issue_pc", bus.instr_pc, 32'hC);
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        chk("halted_set", 32'(halted), 1);
        chk("halted_noreq", 32'(bus.imem_req), 0);
        chk("halted_novalid", 32'(bus.instr_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            redirect = (i == 1);
            redirect_target = 32'h300;
            halt = (i == 2);
            @(negedge clk);
            chk("halted_hold", 32'(halted), 1);
            chk("halted_hold_noreq", 32'(bus.imem_req), 0);
        end
        @(posedge clk); #1;
        exc = 1'b1;
        push_exp(32'h80);
        @(negedge clk);
        @(posedge clk); #1;
        exc = 1'b0;
        @(negedge clk);
        chk("wake_halted", 32'(halted), 0);
        chk("wake_req", 32'(bus.imem_req), 1);
        chk("wake_addr", bus.imem_addr, 32'h80);
        drain_and_park("drain_halt");

        // Wrap from 0xFFFF_FFFC to 0, then async reset in the middle of a fetch.
        do_reset();
        mem_delay = 2;
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        @(negedge clk);
        chk("wrap_first_addr", bus.imem_addr, 32'h0);
        @(posedge clk); #1;
        redirect = 1'b0;
        mem_delay = 0;
        wait_fetch("wrap_reach_top", 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc", pc, 32'h0);
        wait_fetch("wrap_reach_zero", 32'h0);
        mem_delay = 5;
        drain_and_park("drain_wrap");
        @(posedge clk); #3;
        chk("midrst_pre_req", 32'(bus.imem_req), 1);
        reset = 1'b0;
        #1;
        chk("midrst_req", 32'(bus.imem_req), 0);
        chk("midrst_addr", bus.imem_addr, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", 32'(bus.instr_valid), 0);
        chk("midrst_instr", bus.instr, 0);
        chk("midrst_halted", 32'(halted), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
